// File: rtl/fsm10_pkg.sv
// Shared types and the reference model for the 10-state fsm block and its sequencer.
package fsm10_pkg;

  typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, S8, S9} state_e;

  typedef enum logic [2:0] {IDLE, LAUNCH, HOLD, RELEASE, ERR} seq_state_e;

  localparam int unsigned RELEASE_CYCLES = 6;

  function automatic state_e fsm10_next(state_e s, logic go, logic jmp);
    state_e n;
    n = S0;
    case (s)
      S0: n = (go && jmp) ? S3 : (go ? S1 : S0);
      S1: n = jmp ? S3 : S2;
      S2: n = S3;
      S3: n = jmp ? S3 : S4;
      S4: n = jmp ? S3 : S5;
      S5: n = jmp ? S3 : S6;
      S6: n = jmp ? S3 : S7;
      S7: n = jmp ? S3 : S8;
      S8: n = jmp ? S3 : S9;
      S9: n = jmp ? S3 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic fsm10_y1(state_e s);
    return (s == S3);
  endfunction

endpackage

// File: rtl/fsm10_shadow.sv
// Shadow copy of the fsm block state, advanced with the driven go/jmp,
// plus the y1 divergence check against it.
module fsm10_shadow
  import fsm10_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  input  logic jmp_i,
  input  logic y1_i,
  input  logic chk_en_i,
  output logic mismatch_o
);

  state_e shadow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) shadow_q <= S0;
    else       shadow_q <= fsm10_next(shadow_q, go_i, jmp_i);
  end

  // S1/S2 are unreachable under correct steering, so landing there is a fault too
  assign mismatch_o = chk_en_i &
                      ((y1_i != fsm10_y1(shadow_q)) || (shadow_q == S1) || (shadow_q == S2));

endmodule

// File: rtl/fsm10_sequencer.sv
// Burst sequencer: steers the fsm block into S3 for cmd_len cycles and
// watches its y1 output against a shadow model.
//   state   | meaning
//   IDLE    | fsm parked in S0, ready for a request
//   LAUNCH  | go=jmp=1, fsm jumps to S3
//   HOLD    | fsm held in S3 while remain counts down
//   RELEASE | fsm walks S4..S9, new request may chain in
//   ERR     | y1 diverged, stuck until reset
module fsm10_sequencer
  import fsm10_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             cmd_ready_o,
  output logic             go_o,
  output logic             jmp_o,
  input  logic             y1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:0]      burst_cnt_o
);

  localparam int REL_W = $clog2(RELEASE_CYCLES);

  seq_state_e       state_q;
  logic [LEN_W-1:0] remain_q;
  logic [REL_W-1:0] rel_cnt_q;
  logic [15:0]      burst_cnt_q;
  logic [LEN_W-1:0] len_eff;
  logic             mismatch;

  assign len_eff = (cmd_len_i == '0) ? LEN_W'(1) : cmd_len_i;

  assign go_o        = (state_q == LAUNCH);
  assign jmp_o       = (state_q == LAUNCH) || ((state_q == HOLD) && (remain_q > LEN_W'(1)));
  assign done_o      = (state_q == HOLD) && (remain_q == LEN_W'(1));
  assign cmd_ready_o = (state_q == IDLE) || (state_q == RELEASE);
  assign busy_o      = (state_q != IDLE);
  assign err_o       = (state_q == ERR);
  assign burst_cnt_o = burst_cnt_q;

  fsm10_shadow u_shadow (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .go_i       (go_o),
    .jmp_i      (jmp_o),
    .y1_i       (y1_i),
    .chk_en_i   (state_q != ERR),
    .mismatch_o (mismatch)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      rel_cnt_q   <= '0;
      burst_cnt_q <= '0;
    end else if (mismatch) begin
      state_q <= ERR;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            state_q  <= LAUNCH;
            remain_q <= len_eff;
          end
        end
        LAUNCH: state_q <= HOLD;
        HOLD: begin
          if (remain_q == LEN_W'(1)) begin
            state_q     <= RELEASE;
            rel_cnt_q   <= REL_W'(RELEASE_CYCLES - 1);
            burst_cnt_q <= burst_cnt_q + 16'd1;
          end else begin
            remain_q <= remain_q - LEN_W'(1);
          end
        end
        RELEASE: begin
          if (cmd_valid_i) begin
            state_q  <= LAUNCH;
            remain_q <= len_eff;
          end else if (rel_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            rel_cnt_q <= rel_cnt_q - REL_W'(1);
          end
        end
        default: state_q <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm10_sequencer.sv
// Directed bench for fsm10_sequencer driving a behavioural fsm block,
// with per-cycle expectations queued at stimulus time.
module tb_fsm10_sequencer;
  import fsm10_pkg::*;

  localparam int LEN_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic [LEN_W-1:0] cmd_len_i = '0;
  logic             cmd_ready_o, go_o, jmp_o, busy_o, done_o, err_o;
  logic [15:0]      burst_cnt_o;
  logic             y1;
  logic             force_low = 1'b0;
  state_e           fsm_q;

  typedef struct packed {
    logic go, jmp, y1, done, busy, ready, err;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   s0_hits = 0;
  logic watch_s0 = 1'b0;

  fsm10_sequencer #(.LEN_W(LEN_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_ready_o (cmd_ready_o),
    .go_o        (go_o),
    .jmp_o       (jmp_o),
    .y1_i        (y1),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .burst_cnt_o (burst_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // stand-in for the fsm block; its reset is tied to ~rst_n = rst
  always @(posedge clk_i) begin
    if (rst_i) fsm_q <= S0;
    else       fsm_q <= fsm10_next(fsm_q, go_o, jmp_o);
  end

  assign y1 = force_low ? 1'b0 : fsm10_y1(fsm_q);

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic push(input logic go, input logic jmp, input logic y, input logic dn,
                      input logic bsy, input logic rdy, input logic er);
    rec_t r;
    r.go = go; r.jmp = jmp; r.y1 = y; r.done = dn;
    r.busy = bsy; r.ready = rdy; r.err = er;
    q.push_back(r);
  endtask

  // LAUNCH, n HOLD cycles, rel RELEASE cycles, and IDLE if the release completes
  task automatic push_burst(input int n, input int rel);
    push(1, 1, 0, 0, 1, 0, 0);
    for (int h = 1; h <= n; h++) push(0, h < n, 1, h == n, 1, 0, 0);
    for (int r = 0; r < rel; r++) push(0, 0, 0, 0, 1, 1, 0);
    if (rel == int'(RELEASE_CYCLES)) push(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic drain(input int k);
    rec_t obs, exp;
    for (int i = 0; i < k; i++) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL scoreboard_empty cyc=%0d observed=0 expected=>0", cyc);
      end
      if (q.size() > 0) begin
        exp = q.pop_front();
        obs = '{go_o, jmp_o, y1, done_o, busy_o, cmd_ready_o, err_o};
        checks++;
        assert (obs === exp) else begin
          failures++;
          $error("FAIL cycle_outputs cyc=%0d observed(go,jmp,y1,done,busy,ready,err)=%b expected=%b",
                 cyc, obs, exp);
        end
      end
      if (watch_s0 && fsm_q == S0) s0_hits++;
      step();
    end
  endtask

  task automatic single_burst(input int len, input int n_eff, input int cnt_exp, input string tag);
    cyc = 0;
    check_val({tag, "_ready"}, int'(cmd_ready_o), 1);
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(len);
    push_burst(n_eff, RELEASE_CYCLES);
    step();
    cmd_valid_i = 1'b0;
    drain(q.size());
    check_val({tag, "_burst_cnt"}, int'(burst_cnt_o), cnt_exp);
  endtask

  initial begin
    // reset held for two edges
    step();
    step();
    rst_i = 1'b0;
    cyc = 0;
    push(0, 0, 0, 0, 0, 1, 0);
    drain(1);
    check_val("reset_burst_cnt", int'(burst_cnt_o), 0);
    check_val("reset_fsm_state", int'(fsm_q), int'(S0));

    single_burst(1, 1, 1, "single");
    single_burst(4, 4, 2, "multi");

    // chained: second request presented while the fsm sits in S6
    cyc = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(2);
    push_burst(2, 3);
    step();
    cmd_valid_i = 1'b0;
    drain(1);
    watch_s0 = 1'b1;
    drain(4);
    check_val("chain_fsm_s6", int'(fsm_q), int'(S6));
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(3);
    push_burst(3, RELEASE_CYCLES);
    drain(1);
    cmd_valid_i = 1'b0;
    drain(4);
    watch_s0 = 1'b0;
    check_val("chain_no_s0", s0_hits, 0);
    drain(q.size());
    check_val("chain_burst_cnt", int'(burst_cnt_o), 4);

    single_burst(0, 1, 5, "zero_len");

    // y1 forced low in the second HOLD cycle
    cyc = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(4);
    push(1, 1, 0, 0, 1, 0, 0);
    push(0, 1, 1, 0, 1, 0, 0);
    push(0, 1, 0, 0, 1, 0, 0);
    push(0, 0, 1, 0, 1, 0, 1);
    push(0, 0, 0, 0, 1, 0, 1);
    push(0, 0, 0, 0, 1, 0, 1);
    push(0, 0, 0, 0, 1, 0, 1);
    step();
    cmd_valid_i = 1'b0;
    drain(2);
    force_low = 1'b1;
    #1;
    drain(1);
    force_low = 1'b0;
    #1;
    drain(4);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    push(0, 0, 0, 0, 0, 1, 0);
    drain(1);
    check_val("err_rst_burst_cnt", int'(burst_cnt_o), 0);

    // reset in the middle of HOLD
    cyc = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(5);
    push(1, 1, 0, 0, 1, 0, 0);
    push(0, 1, 1, 0, 1, 0, 0);
    push(0, 1, 1, 0, 1, 0, 0);
    step();
    cmd_valid_i = 1'b0;
    drain(3);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    push(0, 0, 0, 0, 0, 1, 0);
    drain(1);
    check_val("midhold_fsm_state", int'(fsm_q), int'(S0));
    check_val("midhold_burst_cnt", int'(burst_cnt_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm10_sequencer.md
# fsm10_sequencer

- Initiator-side driver for the 10-state `fsm` block: it generates that block's `go`/`jmp` inputs and checks its `y1` output.
- Accepts burst commands over a valid/ready handshake and steers the FSM into S3, so that `y1` is high for exactly the requested number of cycles.
- Keeps a shadow copy of the FSM state and flags any `y1` divergence as a sticky error.
- Sits beside `fsm` in the lab top level. The top level ties `fsm.rst_n = ~rst`.

## Interface
Parameters:
- `LEN_W`, default 8: width of the burst-length field.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `cmd_valid`  in  1: a burst request is present.
- `cmd_len`  in  `LEN_W`: required number of `y1`-high cycles; 0 is treated as 1.
- `cmd_ready`  out  1: a request can be accepted this cycle.
- `go`  out  1: drives `fsm.go`.
- `jmp`  out  1: drives `fsm.jmp`.
- `y1`  in  1: from `fsm.y1`.
- `busy`  out  1: high whenever the sequencer is not in IDLE.
- `done`  out  1: one-cycle pulse on the last `y1`-high cycle of a burst.
- `err`  out  1: sticky error flag; cleared only by `rst`.
- `burst_cnt`  out  16: number of completed bursts; wraps at 2^16.

## Operation
Sequencer states: IDLE, LAUNCH, HOLD, RELEASE, ERR. All outputs are Moore outputs, decoded from registered state only.

- **Reset** (`rst` high at an edge): state IDLE, shadow = S0, `go`=0, `jmp`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `burst_cnt`=0.
- **Shadow state:** updated every edge using the FSM's own next-state rules, applied to the `go`/`jmp` values being driven.
- **Handshake:** a request is accepted at an edge where `cmd_valid & cmd_ready`.
  - `cmd_ready` is 1 in IDLE and RELEASE, 0 in every other state.
  - On acceptance, `cmd_len` is latched (0 becomes 1) into `remain` and the next state is LAUNCH.
- **IDLE:** shadow is S0; `go`=0, `jmp`=0, so the FSM holds in S0.
- **LAUNCH:** one cycle with `go`=1, `jmp`=1. This sends the FSM to S3 from S0 and from S4–S9. Next state is HOLD.
- **HOLD:** shadow is S3.
  - `jmp`=1 while `remain`>1; `remain` decrements each cycle.
  - When `remain`==1: `jmp`=0, `done`=1, `burst_cnt` increments, next state is RELEASE.
- **RELEASE:** shadow walks S4 through S9 with `go`=0, `jmp`=0.
  - After S9 the shadow returns to S0 and the state becomes IDLE.
  - A request accepted in any RELEASE cycle, including the S9 cycle, goes to LAUNCH. There is no return to S0 between bursts.
- **Check:** every cycle outside reset and ERR, `y1` must equal (shadow==S3). On a mismatch at an edge:
  - next state is ERR and `err` becomes 1;
  - in ERR, `go`=0, `jmp`=0, `cmd_ready`=0 and `busy`=1;
  - ERR is left only via `rst`.
- **Excluded shadow states:** S1 and S2 are never entered by the sequencer. Reaching either one counts as a mismatch and goes to ERR.
- **Reset mid-operation:** reset in any state returns both the sequencer and the FSM to IDLE/S0. Any burst in progress is discarded and `burst_cnt` is cleared.

## Timing
- **Request to `y1`:**
  - accept at edge E0;
  - LAUNCH in cycle 1;
  - `y1`=1 in cycles 2 through N+1;
  - `done` in cycle N+1.
- **Return to rest:** RELEASE occupies cycles N+2 through N+7 (S4–S9), and IDLE is reached in cycle N+8. Total request-to-IDLE is N+8 cycles.
- **Back-to-back bursts:** with a request accepted in RELEASE cycle k, LAUNCH is in cycle k+1 and `y1` is high from cycle k+2.
- **Error flag latency:** `err` rises in the cycle after the mismatching cycle.

## Structure
- **Shared package `fsm10_pkg`** gains:
  - `seq_state_e` {IDLE, LAUNCH, HOLD, RELEASE, ERR};
  - `RELEASE_CYCLES` = 6;
  - function `fsm10_next(state_e, go, jmp)`, returning `state_e`;
  - function `fsm10_y1(state_e)`, returning logic.
- **Reference model:** the two package functions are the single reference model. The testbench shares them.
- **Sub-module:** one sub-module, `fsm10_shadow`, holds the shadow-state register and its `y1` check. The sequencer FSM, the `remain` counter and `burst_cnt` stay in `fsm10_sequencer`.

## Test plan
1. **Reset:** hold `rst` for 2 cycles → `go`=0, `jmp`=0, `cmd_ready`=1, `busy`=0, `err`=0, `burst_cnt`=0; FSM is in S0 and `y1`=0.
2. **Single-cycle burst:** `cmd_len`=1 accepted at E0 → `go`=`jmp`=1 in cycle 1; `y1`=1 only in cycle 2, with `done`=1 in cycle 2; `y1`=0 in cycles 3–8; IDLE in cycle 9; `burst_cnt`=1.
3. **Multi-cycle burst:** `cmd_len`=4 → `y1` high in cycles 2–5; `jmp`=1 in cycles 2–4 and 0 in cycle 5; `done` in cycle 5.
4. **Chained bursts:** `cmd_len`=2, then `cmd_len`=3 presented while the shadow is S6 → the next cycle is LAUNCH; `y1` is high for exactly 3 cycles; the FSM never visits S0 between bursts; `burst_cnt`=2.
5. **Zero length:** `cmd_len`=0 → identical response to scenario 2.
6. **Error and recovery:**
   - Force `y1`=0 during a HOLD cycle → `err`=1 on the next cycle, `go`=`jmp`=0, `cmd_ready`=0 thereafter.
   - Assert `rst` → IDLE with `err`=0.
   - Separately, assert `rst` mid-HOLD → IDLE/S0 on the next cycle.
